// File: rtl/inst_encoder_loader_pkg.sv
// Shared opcode/funct3 constants, FSM states and the field-to-word
// instruction encoder used by the IMEM loader.
package inst_encoder_loader_pkg;

    localparam int WORD_BITWIDTH    = 32;
    localparam int REG_NUM_BITWIDTH = 5;

    localparam logic [6:0] INST_R     = 7'b0110011;
    localparam logic [6:0] INST_I_LD  = 7'b0000011;
    localparam logic [6:0] INST_I_IMM = 7'b0010011;
    localparam logic [6:0] INST_S     = 7'b0100011;
    localparam logic [6:0] INST_B     = 7'b1100011;
    localparam logic [6:0] INST_J     = 7'b1101111;
    localparam logic [6:0] INST_U     = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic                     ok;
        logic [WORD_BITWIDTH-1:0] word;
    } enc_t;

    function automatic enc_t encode(
        input logic [6:0]                  op,
        input logic [REG_NUM_BITWIDTH-1:0] rd,
        input logic [REG_NUM_BITWIDTH-1:0] rs1,
        input logic [REG_NUM_BITWIDTH-1:0] rs2,
        input logic [2:0]                  f3,
        input logic                        f7b5,
        input logic [WORD_BITWIDTH-1:0]    imm
    );
        enc_t e;
        logic sx12;
        logic sx13;
        logic sx21;
        sx12   = (imm[31:11] == {21{imm[11]}});
        sx13   = (imm[31:12] == {20{imm[12]}});
        sx21   = (imm[31:20] == {12{imm[20]}});
        e.ok   = 1'b0;
        e.word = '0;
        unique case (1'b1)
            (op == INST_R): begin
                e.ok   = 1'b1;
                e.word = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, op};
            end
            (op == INST_I_LD): begin
                e.ok   = sx12;
                e.word = {imm[11:0], rs1, f3, rd, op};
            end
            (op == INST_I_IMM): begin
                e.ok   = sx12;
                e.word = {imm[11:0], rs1, f3, rd, op};
                // srai shares funct3 with srli; bit 30 selects it
                if (f3 == F3_SR) begin
                    e.word[30] = f7b5;
                end
            end
            (op == INST_S): begin
                e.ok   = sx12;
                e.word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            (op == INST_B): begin
                e.ok   = sx13 && !imm[0];
                e.word = {imm[12], imm[10:5], rs2, rs1, f3,
                          imm[4:1], imm[11], op};
            end
            (op == INST_J): begin
                e.ok   = sx21 && !imm[0];
                e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            (op == INST_U): begin
                e.ok   = (imm[11:0] == 12'h000);
                e.word = {imm[31:12], rd, op};
            end
            default: begin
                e.ok   = 1'b0;
                e.word = '0;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/inst_encoder_loader_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Packs field-level RISC-V commands into instruction words and
// streams them to consecutive IMEM addresses through a small FIFO.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int ADDR_BITWIDTH = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_BITWIDTH-1:0]    start_addr,
    input  logic                        finish,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  in_opcode,
    input  logic [REG_NUM_BITWIDTH-1:0] in_rd,
    input  logic [REG_NUM_BITWIDTH-1:0] in_rs1,
    input  logic [REG_NUM_BITWIDTH-1:0] in_rs2,
    input  logic [2:0]                  in_funct3,
    input  logic                        in_funct7b5,
    input  logic [WORD_BITWIDTH-1:0]    in_imm,
    output logic                        mem_we,
    input  logic                        mem_ready,
    output logic [ADDR_BITWIDTH-1:0]    mem_addr,
    output logic [WORD_BITWIDTH-1:0]    mem_wdata,
    output logic                        done,
    output logic                        err,
    output logic [7:0]                  err_count
);

    state_t                   state;
    state_t                   state_nx;
    enc_t                     enc;
    logic                     accept;
    logic                     enc_valid;
    logic [WORD_BITWIDTH-1:0] enc_word;
    logic                     enc_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [WORD_BITWIDTH-1:0] fifo_head;
    logic                     session_go;

    assign enc = encode(in_opcode, in_rd, in_rs1, in_rs2,
                        in_funct3, in_funct7b5, in_imm);

    assign in_ready   = (state == ST_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign session_go = (state == ST_IDLE) && start;

    assign mem_we    = !fifo_empty &&
                       ((state == ST_LOAD) || (state == ST_DRAIN));
    assign fifo_pop  = mem_we && mem_ready;
    // the staged word waits here while the FIFO is full and stalled
    assign enc_push  = enc_valid && (!fifo_full || fifo_pop);
    assign mem_wdata = mem_we ? fifo_head : '0;
    assign done      = (state == ST_DONE);

    sync_fifo #(
        .WIDTH (WORD_BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (enc_push),
        .wdata (enc_word),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (finish) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !enc_valid) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid <= 1'b0;
            enc_word  <= '0;
        end else if (accept && enc.ok) begin
            enc_valid <= 1'b1;
            enc_word  <= enc.word;
        end else if (enc_push) begin
            enc_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= '0;
        end else if (session_go) begin
            mem_addr <= start_addr;
        end else if (fifo_pop) begin
            mem_addr <= mem_addr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (session_go) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (accept && !enc.ok) begin
            err <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: hand-encoded words,
// reject cases, backpressure, address wrap and mid-drain reset.
module tb_inst_encoder_loader;
    import inst_encoder_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic        finish;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_imm;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [9:0]  cap_a[$];
    logic [31:0] cap_d[$];
    logic [31:0] exp_d[$];

    always #5 clk = ~clk;

    inst_encoder_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .finish      (finish),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_imm      (in_imm),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (done),
        .err         (err),
        .err_count   (err_count)
    );

    always @(posedge clk) begin
        if (rst_n && mem_we && mem_ready) begin
            cap_a.push_back(mem_addr);
            cap_d.push_back(mem_wdata);
        end
        if (rst_n && done) begin
            done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_caps();
        cap_a.delete();
        cap_d.delete();
        exp_d.delete();
    endtask

    task automatic do_start(input logic [9:0] a);
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_finish();
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm, input logic good,
                        input logic [31:0] exp);
        int n;
        in_opcode   = op;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_imm      = imm;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("send_timeout", 32'd1, 32'd0);
        end
        if (good) begin
            exp_d.push_back(exp);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_writes(input logic [9:0] a0);
        int m;
        logic [9:0] a;
        check("n_writes", 32'(cap_d.size()), 32'(exp_d.size()));
        m = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
        for (int i = 0; i < m; i++) begin
            a = a0 + 10'(i);
            check($sformatf("addr%0d", i), 32'(cap_a[i]), 32'(a));
            check($sformatf("data%0d", i), cap_d[i], exp_d[i]);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        start_addr  = '0;
        finish      = 1'b0;
        in_valid    = 1'b0;
        in_opcode   = '0;
        in_rd       = '0;
        in_rs1      = '0;
        in_rs2      = '0;
        in_funct3   = '0;
        in_funct7b5 = 1'b0;
        in_imm      = '0;
        mem_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single addi
        clear_caps();
        do_start(10'h010);
        check("load_in_ready", 32'(in_ready), 32'd1);
        send(INST_I_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,
             1'b1, 32'h00500093);
        do_finish();
        wait_done();
        check_writes(10'h010);
        check("a_err", 32'(err), 32'd0);

        // all formats, plus a start ignored mid-session
        clear_caps();
        do_start(10'h020);
        send(INST_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,
             1'b1, 32'h002081B3);
        send(INST_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,
             1'b1, 32'h402081B3);
        do_start(10'h300);
        send(INST_S, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8,
             1'b1, 32'h0020A423);
        send(INST_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4,
             1'b1, 32'hFE208EE3);
        send(INST_J, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,
             1'b1, 32'h008000EF);
        send(INST_I_LD, 5'd5, 5'd2, 5'd0, 3'd2, 1'b0, -32'sd8,
             1'b1, 32'hFF812283);
        send(INST_U, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000,
             1'b1, 32'h123452B7);
        send(INST_I_IMM, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd3,
             1'b1, 32'h4030D093);
        do_finish();
        wait_done();
        check_writes(10'h020);
        check("b_err", 32'(err), 32'd0);

        // rejects, plus the most negative legal I immediate
        clear_caps();
        do_start(10'h040);
        send(INST_B, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 1'b0, 32'd0);
        send(INST_I_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096,
             1'b0, 32'd0);
        send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        send(INST_J, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, 32'd0);
        send(INST_U, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345001,
             1'b0, 32'd0);
        send(INST_S, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, -32'sd2049,
             1'b0, 32'd0);
        send(INST_I_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, -32'sd2048,
             1'b1, 32'h80000093);
        do_finish();
        wait_done();
        check_writes(10'h040);
        check("c_err", 32'(err), 32'd1);
        check("c_err_count", 32'(err_count), 32'd6);

        // backpressure: FIFO plus staging register absorb five
        clear_caps();
        mem_ready = 1'b0;
        do_start(10'h080);
        check("d_err_clr", 32'(err), 32'd0);
        check("d_cnt_clr", 32'(err_count), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            send(INST_I_IMM, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i),
                 1'b1, (32'(i) << 20) | (32'(i) << 7) | 32'h13);
        end
        @(negedge clk);
        check("d_in_ready_low", 32'(in_ready), 32'd0);
        check("d_mem_we_held", 32'(mem_we), 32'd1);
        check("d_addr_held", 32'(mem_addr), 32'h080);
        check("d_wdata_held", mem_wdata, 32'h00100093);
        repeat (4) @(negedge clk);
        check("d_no_writes", 32'(cap_d.size()), 32'd0);
        mem_ready = 1'b1;
        send(INST_I_IMM, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'd6,
             1'b1, 32'h00600313);
        do_finish();
        wait_done();
        check_writes(10'h080);

        // address wrap
        clear_caps();
        do_start(10'h3FF);
        send(INST_I_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1,
             1'b1, 32'h00100093);
        send(INST_I_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2,
             1'b1, 32'h00200113);
        do_finish();
        wait_done();
        check_writes(10'h3FF);

        // reset during drain flushes pending words
        clear_caps();
        mem_ready = 1'b0;
        do_start(10'h100);
        send(INST_R, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        send(INST_R, 5'd4, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        do_finish();
        check("e_drain_we", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_we", 32'(mem_we), 32'd0);
        check("e_rst_ready", 32'(in_ready), 32'd0);
        check("e_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("e_idle_we", 32'(mem_we), 32'd0);
        do_start(10'h000);
        do_finish();
        wait_done();
        check_writes(10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
